// File: rtl/user_rq_mux_encoder.sv
// ---------------------------------------------------------------------------
// user_rq_mux_encoder
//   Multi-channel requester-request TLP encoder. NUM_CH submitters present
//   MemRd/MemWr 32/64 commands; a round-robin arbiter takes one at a time and
//   emits it on the 128-bit AXI-S RQ interface as a descriptor beat followed
//   by ceil(length/4) payload beats for writes.
//
// Ports
//   user_clk, reset          clock, synchronous active-high reset
//   s_axis_rq_*              AXI-S requester request master (tdata/tkeep/
//                            tuser/tlast/tvalid out, tready in)
//   cmd_valid/cmd_ready      per-channel command handshake (ready one-hot)
//   cmd_type/tag/addr/length/first_be/last_be   packed per-channel command
//   wr_data/wr_valid/wr_ready                   per-channel payload stream
//   done                     1-cycle pulse when the TLP was fully accepted
//   cmd_err                  1-cycle pulse when a command was rejected
//   busy                     encoder is emitting a TLP
// ---------------------------------------------------------------------------
module user_rq_mux_encoder #(
  parameter int          AXI4_RQ_TUSER_WIDTH = 62,
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          NUM_CH              = 4,
  parameter int          MAX_PAYLOAD_DW      = 256
) (
  input  logic                           user_clk,
  input  logic                           reset,
  input  logic                           s_axis_rq_tready,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic [NUM_CH-1:0]              cmd_valid,
  output logic [NUM_CH-1:0]              cmd_ready,
  input  logic [3*NUM_CH-1:0]            cmd_type,
  input  logic [8*NUM_CH-1:0]            cmd_tag,
  input  logic [64*NUM_CH-1:0]           cmd_addr,
  input  logic [11*NUM_CH-1:0]           cmd_length,
  input  logic [4*NUM_CH-1:0]            cmd_first_be,
  input  logic [4*NUM_CH-1:0]            cmd_last_be,
  input  logic [C_DATA_WIDTH*NUM_CH-1:0] wr_data,
  input  logic [NUM_CH-1:0]              wr_valid,
  output logic [NUM_CH-1:0]              wr_ready,
  output logic [NUM_CH-1:0]              done,
  output logic [NUM_CH-1:0]              cmd_err,
  output logic                           busy
);

  localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [10:0]       MAX_LEN = 11'(MAX_PAYLOAD_DW);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state;
  logic [CH_W-1:0] rr_ptr;

  logic [1:0]      lat_type;   // bit0 = write, bit1 = 64-bit addressing
  logic [7:0]      lat_tag;
  logic [63:0]     lat_addr;
  logic [10:0]     lat_len;
  logic [3:0]      lat_fbe;
  logic [3:0]      lat_lbe;
  logic [CH_W-1:0] lat_ch;
  logic [10:0]     rem;

  logic            gnt_found;
  logic [CH_W-1:0] gnt_idx;
  logic [2:0]      g_type;
  logic [10:0]     g_len;
  logic            g_illegal;
  logic            data_hs;

  // Remaining-DW counter never wraps below zero on the final short beat.
  function automatic logic [10:0] sat_sub4(input logic [10:0] r);
    return (r >= 11'd4) ? (r - 11'd4) : 11'd0;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_for_rem(input logic [10:0] r);
    case (r)
      11'd1:   return KEEP_WIDTH'(4'b0001);
      11'd2:   return KEEP_WIDTH'(4'b0011);
      11'd3:   return KEEP_WIDTH'(4'b0111);
      default: return KEEP_WIDTH'(4'b1111);
    endcase
  endfunction

  // Round-robin search starting at rr_ptr, wrapping at NUM_CH.
  always_comb begin
    int c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!gnt_found && cmd_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
  end

  assign g_type    = cmd_type[int'(gnt_idx)*3 +: 3];
  assign g_len     = cmd_length[int'(gnt_idx)*11 +: 11];
  assign g_illegal = g_type[2] || (g_len == 11'd0) || (g_type[0] && (g_len > MAX_LEN));
  assign cmd_ready = (state == IDLE && !reset && gnt_found) ? (NUM_CH'(1) << gnt_idx) : '0;
  assign data_hs   = (state == DATA) && wr_valid[lat_ch] && s_axis_rq_tready;
  assign busy      = (state != IDLE);

  // Control: FSM, arbiter pointer and status pulses.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      done    <= '0;
      cmd_err <= '0;
    end else begin
      done    <= '0;
      cmd_err <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
            if (g_illegal) cmd_err <= NUM_CH'(1) << gnt_idx;
            else           state   <= HDR;
          end
        end
        HDR: begin
          if (s_axis_rq_tready) begin
            if (lat_type[0]) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              done  <= NUM_CH'(1) << lat_ch;
            end
          end
        end
        DATA: begin
          if (data_hs && (rem <= 11'd4)) begin
            state <= IDLE;
            done  <= NUM_CH'(1) << lat_ch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: latched command fields and payload counter (no reset needed).
  always_ff @(posedge user_clk) begin
    if (state == IDLE && gnt_found) begin
      lat_type <= g_type[1:0];
      lat_tag  <= cmd_tag[int'(gnt_idx)*8 +: 8];
      lat_addr <= cmd_addr[int'(gnt_idx)*64 +: 64];
      lat_len  <= g_len;
      lat_fbe  <= cmd_first_be[int'(gnt_idx)*4 +: 4];
      lat_lbe  <= cmd_last_be[int'(gnt_idx)*4 +: 4];
      lat_ch   <= gnt_idx;
    end
    if (state == HDR && s_axis_rq_tready) rem <= lat_len;
    else if (data_hs)                     rem <= sat_sub4(rem);
  end

  // AXI-S beat generation from the current state and latched command.
  always_comb begin
    logic [63:0] addr_al;
    s_axis_rq_tvalid = 1'b0;
    s_axis_rq_tdata  = '0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tuser  = '0;
    s_axis_rq_tlast  = 1'b0;
    wr_ready         = '0;
    addr_al          = lat_addr & ~64'h3;
    case (state)
      HDR: begin
        s_axis_rq_tvalid = 1'b1;
        s_axis_rq_tkeep  = '1;
        s_axis_rq_tlast  = !lat_type[0];
        s_axis_rq_tdata  = {8'h00, 16'h0000, lat_tag,
                            REQUESTER_ID, 1'b0, {3'b000, lat_type[0]}, lat_len,
                            lat_type[1] ? addr_al : {32'h0, addr_al[31:0]}};
        s_axis_rq_tuser[3:0]   = lat_fbe;
        s_axis_rq_tuser[7:4]   = (lat_len == 11'd1) ? 4'b0000 : lat_lbe;
        s_axis_rq_tuser[27:24] = 4'(lat_ch);
      end
      DATA: begin
        s_axis_rq_tvalid = wr_valid[lat_ch];
        s_axis_rq_tdata  = wr_data[int'(lat_ch)*C_DATA_WIDTH +: C_DATA_WIDTH];
        s_axis_rq_tkeep  = keep_for_rem(rem);
        s_axis_rq_tlast  = (rem <= 11'd4);
        wr_ready[lat_ch] = s_axis_rq_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_user_rq_mux_encoder.sv
module tb_user_rq_mux_encoder;
  localparam int NCH = 4;

  logic              user_clk = 1'b0;
  logic              reset;
  logic              s_axis_rq_tready;
  logic [127:0]      s_axis_rq_tdata;
  logic [3:0]        s_axis_rq_tkeep;
  logic [61:0]       s_axis_rq_tuser;
  logic              s_axis_rq_tlast;
  logic              s_axis_rq_tvalid;
  logic [NCH-1:0]    cmd_valid;
  logic [NCH-1:0]    cmd_ready;
  logic [3*NCH-1:0]  cmd_type;
  logic [8*NCH-1:0]  cmd_tag;
  logic [64*NCH-1:0] cmd_addr;
  logic [11*NCH-1:0] cmd_length;
  logic [4*NCH-1:0]  cmd_first_be;
  logic [4*NCH-1:0]  cmd_last_be;
  logic [128*NCH-1:0] wr_data;
  logic [NCH-1:0]    wr_valid;
  logic [NCH-1:0]    wr_ready;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    cmd_err;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 user_clk = ~user_clk;

  user_rq_mux_encoder #(.NUM_CH(NCH)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_axis_rq_tready(s_axis_rq_tready), .s_axis_rq_tdata(s_axis_rq_tdata),
    .s_axis_rq_tkeep(s_axis_rq_tkeep), .s_axis_rq_tuser(s_axis_rq_tuser),
    .s_axis_rq_tlast(s_axis_rq_tlast), .s_axis_rq_tvalid(s_axis_rq_tvalid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_tag(cmd_tag), .cmd_addr(cmd_addr), .cmd_length(cmd_length),
    .cmd_first_be(cmd_first_be), .cmd_last_be(cmd_last_be),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done(done), .cmd_err(cmd_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, outputs are sampled #1 later.
  task automatic tick();
    @(negedge user_clk);
  endtask

  task automatic set_cmd(input int ch, input logic [2:0] t, input logic [7:0] tag,
                         input logic [63:0] a, input logic [10:0] len,
                         input logic [3:0] fb, input logic [3:0] lb);
    cmd_type[ch*3 +: 3]      = t;
    cmd_tag[ch*8 +: 8]       = tag;
    cmd_addr[ch*64 +: 64]    = a;
    cmd_length[ch*11 +: 11]  = len;
    cmd_first_be[ch*4 +: 4]  = fb;
    cmd_last_be[ch*4 +: 4]   = lb;
    cmd_valid[ch]            = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    s_axis_rq_tready = 1'b1;
    cmd_valid = '0; cmd_type = '0; cmd_tag = '0; cmd_addr = '0;
    cmd_length = '0; cmd_first_be = '0; cmd_last_be = '0;
    wr_data = '0; wr_valid = '0;

    // All channels request legal 1-DW reads from reset onward.
    for (int c = 0; c < NCH; c++) set_cmd(c, 3'b000, 8'(c), 64'h100, 11'd1, 4'hF, 4'h0);
    tick(); tick();
    #1;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'h0);
    tick(); reset = 1'b0; #1;
    chk("rst_tvalid", 128'(s_axis_rq_tvalid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);

    // Grant order 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      if (g != 0) tick();
      #1;
      chk($sformatf("rr_grant%0d", g), 128'(cmd_ready), 128'(4'b0001 << (g % 4)));
      tick(); #1;
      chk($sformatf("rr_hdr_ready%0d", g), 128'(cmd_ready), 128'h0);
      chk($sformatf("rr_hdr_ch%0d", g), 128'(s_axis_rq_tuser[27:24]), 128'(g % 4));
    end
    tick(); cmd_valid = '0; #1;
    chk("rr_done0", 128'(done), 128'h1);

    // Ch0 MemRd32 len 1.
    tick();
    set_cmd(0, 3'b000, 8'h05, 64'h1000_0004, 11'd1, 4'hF, 4'hF);
    #1;
    chk("rd_ready", 128'(cmd_ready), 128'h1);
    tick(); cmd_valid = '0; #1;
    chk("rd_tvalid", 128'(s_axis_rq_tvalid), 128'h1);
    chk("rd_addr", 128'(s_axis_rq_tdata[63:0]), 128'h0000_0000_1000_0004);
    chk("rd_len", 128'(s_axis_rq_tdata[74:64]), 128'h1);
    chk("rd_type", 128'(s_axis_rq_tdata[78:75]), 128'h0);
    chk("rd_reqid", 128'(s_axis_rq_tdata[95:80]), 128'h10EE);
    chk("rd_tag", 128'(s_axis_rq_tdata[127:96]), 128'h05);
    chk("rd_tlast", 128'(s_axis_rq_tlast), 128'h1);
    chk("rd_tuser", 128'(s_axis_rq_tuser), 128'h0F);
    chk("rd_tkeep", 128'(s_axis_rq_tkeep), 128'hF);
    chk("rd_busy", 128'(busy), 128'h1);
    tick(); #1;
    chk("rd_idle_tvalid", 128'(s_axis_rq_tvalid), 128'h0);
    chk("rd_done", 128'(done), 128'h1);
    tick(); #1;
    chk("rd_done_clr", 128'(done), 128'h0);

    // Ch2 MemWr64 len 6.
    set_cmd(2, 3'b011, 8'h22, 64'h0000_0001_2345_6000, 11'd6, 4'hF, 4'hF);
    wr_valid[2] = 1'b1;
    wr_data[2*128 +: 128] = 128'hA3A2A1A0_B3B2B1B0_C3C2C1C0_D3D2D1D0;
    #1;
    chk("wr64_ready", 128'(cmd_ready), 128'h4);
    tick(); cmd_valid = '0; #1;
    chk("wr64_addr", 128'(s_axis_rq_tdata[63:0]), 128'h0000_0001_2345_6000);
    chk("wr64_type", 128'(s_axis_rq_tdata[78:75]), 128'h1);
    chk("wr64_len", 128'(s_axis_rq_tdata[74:64]), 128'h6);
    chk("wr64_tlast_hdr", 128'(s_axis_rq_tlast), 128'h0);
    chk("wr64_tuser", 128'(s_axis_rq_tuser), 128'h0200_00FF);
    tick(); #1;
    chk("wr64_b1_data", s_axis_rq_tdata, 128'hA3A2A1A0_B3B2B1B0_C3C2C1C0_D3D2D1D0);
    chk("wr64_b1_keep", 128'(s_axis_rq_tkeep), 128'hF);
    chk("wr64_b1_last", 128'(s_axis_rq_tlast), 128'h0);
    chk("wr64_wr_ready", 128'(wr_ready), 128'h4);
    chk("wr64_b1_tuser", 128'(s_axis_rq_tuser), 128'h0);
    tick();
    wr_data[2*128 +: 128] = 128'h0000_0000_0000_0000_1111_2222_3333_4444;
    #1;
    chk("wr64_b2_keep", 128'(s_axis_rq_tkeep), 128'h3);
    chk("wr64_b2_last", 128'(s_axis_rq_tlast), 128'h1);
    tick(); wr_valid = '0; #1;
    chk("wr64_done", 128'(done), 128'h4);
    chk("wr64_busy", 128'(busy), 128'h0);

    // Ch1 MemWr32 len 9 with backpressure and payload bubble.
    tick();
    set_cmd(1, 3'b001, 8'h31, 64'hFFFF_FFFF_8000_0013, 11'd9, 4'hE, 4'h1);
    #1;
    chk("wr32_ready", 128'(cmd_ready), 128'h2);
    tick(); cmd_valid = '0; s_axis_rq_tready = 1'b0; #1;
    chk("wr32_addr", 128'(s_axis_rq_tdata[63:0]), 128'h0000_0000_8000_0010);
    chk("wr32_tuser", 128'(s_axis_rq_tuser), 128'h0100_001E);
    tick(); #1;
    chk("wr32_hdr_hold", 128'(s_axis_rq_tvalid), 128'h1);
    chk("wr32_hdr_hold_len", 128'(s_axis_rq_tdata[74:64]), 128'h9);
    s_axis_rq_tready = 1'b1;
    tick(); s_axis_rq_tready = 1'b0; wr_valid[1] = 1'b1;
    wr_data[1*128 +: 128] = 128'h11;
    #1;
    chk("wr32_b1_wait_ready", 128'(wr_ready), 128'h0);
    chk("wr32_b1_wait_data", s_axis_rq_tdata, 128'h11);
    tick(); s_axis_rq_tready = 1'b1; #1;
    chk("wr32_b1_data", s_axis_rq_tdata, 128'h11);
    chk("wr32_b1_keep", 128'(s_axis_rq_tkeep), 128'hF);
    tick(); wr_valid[1] = 1'b0; wr_data[1*128 +: 128] = 128'h22; #1;
    chk("wr32_bubble", 128'(s_axis_rq_tvalid), 128'h0);
    tick(); wr_valid[1] = 1'b1; s_axis_rq_tready = 1'b0; #1;
    chk("wr32_b2_keep", 128'(s_axis_rq_tkeep), 128'hF);
    chk("wr32_b2_last", 128'(s_axis_rq_tlast), 128'h0);
    tick(); s_axis_rq_tready = 1'b1; #1;
    chk("wr32_b2_data", s_axis_rq_tdata, 128'h22);
    tick(); wr_data[1*128 +: 128] = 128'h33; s_axis_rq_tready = 1'b0; #1;
    chk("wr32_b3_keep_wait", 128'(s_axis_rq_tkeep), 128'h1);
    tick(); s_axis_rq_tready = 1'b1; #1;
    chk("wr32_b3_keep", 128'(s_axis_rq_tkeep), 128'h1);
    chk("wr32_b3_last", 128'(s_axis_rq_tlast), 128'h1);
    chk("wr32_b3_data", s_axis_rq_tdata, 128'h33);
    tick(); wr_valid = '0; #1;
    chk("wr32_done", 128'(done), 128'h2);

    // Illegal commands: ch1 len 0, ch3 MemWr len 300.
    tick();
    set_cmd(1, 3'b000, 8'h40, 64'h0, 11'd0, 4'hF, 4'h0);
    #1;
    chk("err1_ready", 128'(cmd_ready), 128'h2);
    tick(); cmd_valid = '0; #1;
    chk("err1_pulse", 128'(cmd_err), 128'h2);
    chk("err1_tvalid", 128'(s_axis_rq_tvalid), 128'h0);
    chk("err1_busy", 128'(busy), 128'h0);
    tick();
    set_cmd(3, 3'b011, 8'h41, 64'h0, 11'd300, 4'hF, 4'hF);
    #1;
    chk("err3_ready", 128'(cmd_ready), 128'h8);
    tick(); cmd_valid = '0; #1;
    chk("err3_pulse", 128'(cmd_err), 128'h8);
    chk("err3_tvalid", 128'(s_axis_rq_tvalid), 128'h0);
    chk("err3_busy", 128'(busy), 128'h0);
    tick(); #1;
    chk("err3_clr", 128'(cmd_err), 128'h0);

    // Reset mid-DATA of a 16-DW write.
    set_cmd(0, 3'b001, 8'h50, 64'h3000, 11'd16, 4'hF, 4'hF);
    wr_valid[0] = 1'b1; wr_data[0 +: 128] = 128'h55;
    tick(); cmd_valid = '0;
    tick(); tick(); #1;
    chk("rstd_in_data", 128'(wr_ready), 128'h1);
    tick(); reset = 1'b1; wr_valid = '0; #1;
    tick(); reset = 1'b0; #1;
    chk("rstd_tvalid", 128'(s_axis_rq_tvalid), 128'h0);
    chk("rstd_busy", 128'(busy), 128'h0);
    chk("rstd_wr_ready", 128'(wr_ready), 128'h0);
    chk("rstd_done", 128'(done), 128'h0);
    tick();
    set_cmd(0, 3'b000, 8'h60, 64'h2000_0008, 11'd2, 4'hF, 4'h3);
    set_cmd(2, 3'b000, 8'h61, 64'h0, 11'd1, 4'hF, 4'h0);
    #1;
    chk("rstd_grant", 128'(cmd_ready), 128'h1);
    tick(); cmd_valid[0] = 1'b0; #1;
    chk("rstd_addr", 128'(s_axis_rq_tdata[63:0]), 128'h2000_0008);
    chk("rstd_len", 128'(s_axis_rq_tdata[74:64]), 128'h2);
    chk("rstd_tuser", 128'(s_axis_rq_tuser[7:0]), 128'h3F);
    tick(); #1;
    chk("rstd_next_grant", 128'(cmd_ready), 128'h4);
    chk("rstd_done0", 128'(done), 128'h1);
    tick(); cmd_valid = '0;
    tick(); #1;
    chk("rstd_done2", 128'(done), 128'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/user_rq_mux_encoder.md
Name: user_rq_mux_encoder

Overview:
Multi-channel, multi-DW successor to the single-requester RQ TLP encoder in the root-port datapath. NUM_CH independent requesters (NVMe queue engines, doorbell writer, PRP fetcher) submit MemRd/MemWr 32/64-bit commands. A round-robin arbiter picks one command at a time and emits it on the 128-bit AXI-S Requester Request interface: one descriptor beat, then zero or more payload beats, with byte-enable and tkeep handling. Per-channel done and error pulses return to the submitters.

Parameters:
AXI4_RQ_TUSER_WIDTH, 62, width of s_axis_rq_tuser
REQUESTER_ID, 16'h10EE, placed in descriptor bits 95:80
C_DATA_WIDTH, 128, AXI-S data width; 128 is the only legal value
KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width
NUM_CH, 4, number of requester channels (1..16)
MAX_PAYLOAD_DW, 256, largest legal MemWr length in DW

Ports:
user_clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_rq_tready  in  1  core ready
s_axis_rq_tdata  out  C_DATA_WIDTH  descriptor/payload
s_axis_rq_tkeep  out  KEEP_WIDTH  DW valid mask
s_axis_rq_tuser  out  AXI4_RQ_TUSER_WIDTH  sideband
s_axis_rq_tlast  out  1  last beat
s_axis_rq_tvalid  out  1  beat valid
cmd_valid  in  NUM_CH  per-channel command request
cmd_ready  out  NUM_CH  one-hot command accept
cmd_type  in  3*NUM_CH  000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64
cmd_tag  in  8*NUM_CH  TLP tag
cmd_addr  in  64*NUM_CH  byte address
cmd_length  in  11*NUM_CH  length in DW
cmd_first_be  in  4*NUM_CH  first DW byte enables
cmd_last_be  in  4*NUM_CH  last DW byte enables
wr_data  in  C_DATA_WIDTH*NUM_CH  per-channel payload, DW0 in bits 31:0
wr_valid  in  NUM_CH  payload valid
wr_ready  out  NUM_CH  payload accept
done  out  NUM_CH  1-cycle pulse, TLP fully accepted by core
cmd_err  out  NUM_CH  1-cycle pulse, command rejected
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, rr pointer 0. All AXI-S outputs, cmd_ready, wr_ready, done, cmd_err and busy are 0. A partial TLP is abandoned; there is no recovery beat.
- States: IDLE, HDR, DATA.
- IDLE arbitration:
  - Grant the first channel with cmd_valid=1, searching from rr_ptr upward with wrap. cmd_ready is one-hot to that channel, combinational, in the same cycle.
  - Latch type, tag, addr, length, BEs and channel index. Set rr_ptr = grant+1 mod NUM_CH.
  - Illegal command: type[2]=1, length=0, or MemWr with length>MAX_PAYLOAD_DW. The command is still accepted, cmd_err[ch] pulses the next cycle, state stays IDLE, no TLP is emitted.
  - Legal command: go to HDR.
- HDR beat: tvalid=1, tkeep=1111, held stable until tready.
  - tdata[127:120]: 127=0, 126:124 attr=000, 123:121 TC=000, 120 ReqID-enable=0.
  - tdata[119:96]: 119:104=16'h0000, 103:96 = tag.
  - tdata[95:64]: 95:80 = REQUESTER_ID, 79 = 0, 78:75 = 0000 for read or 0001 for write, 74:64 = length.
  - tdata[63:0]: 64-bit types use {addr[63:2],2'b00}; 32-bit types use {32'h0, addr[31:2], 2'b00}.
  - tuser[3:0] = first_be. tuser[7:4] = last_be, or 0000 if length=1. tuser[27:24] = channel index. All other tuser bits 0.
  - tlast=1 for reads and 0 for writes.
  - On tready: a read goes to IDLE with done[ch] pulsed the next cycle. A write loads rem=length and goes to DATA.
- DATA:
  - tvalid = wr_valid[ch]; tdata = wr_data[ch]; wr_ready[ch] = tready. Other channels' wr_ready = 0. tuser = 0.
  - tkeep by rem: 1 -> 0001, 2 -> 0011, 3 -> 0111, >=4 -> 1111.
  - tlast = (rem<=4).
  - On handshake: rem = rem-4, floored at 0. If tlast was set, go to IDLE with done[ch] pulsed the next cycle.
  - Bubbles (wr_valid=0) are legal mid-packet.
- Width rules: rem is 11 bits; MAX_PAYLOAD_DW must not exceed 1023. Number of beats = ceil(length/4).
- No new grant is issued while in HDR or DATA. The earliest next cmd_ready is the cycle the FSM is back in IDLE, so the minimum back-to-back gap is 1 idle cycle.
- Simultaneous requests: rotation guarantees each valid channel is served within NUM_CH grants.

Test Plan:
- Ch0 MemRd32, addr 0x1000_0004, len 1, tag 0x05, tready=1 -> one beat; tdata[63:0]=0x0000_0000_1000_0004, tdata[74:64]=1, type 0000, tag 05, tlast=1, tuser[7:0]=0x0F; done[0] one cycle later.
- Ch2 MemWr64, addr 0x0000_0001_2345_6000, len 6, first_be F, last_be F -> header, then beat tkeep 1111 tlast 0, then beat tkeep 0011 tlast 1; tuser[27:24]=2; done[2].
- All 4 channels hold cmd_valid from reset -> grant order 0,1,2,3,0; each cmd_ready single-cycle one-hot.
- MemWr32 len 9, tready toggled 1/0 and wr_valid gap mid-packet -> 3 data beats, tdata/tkeep stable while tready=0, last tkeep 0001.
- Ch1 len 0, and ch3 MemWr len 300 -> cmd_err pulse on the channel, no tvalid, busy stays 0.
- Reset asserted in DATA of a 16-DW write -> next cycle all outputs 0 and state IDLE; a following ch0 read is granted first and emitted correctly.
